// File: rtl/game_select_reset_ctrl.sv
// game_select_reset_ctrl
// Front-panel game selector. The NEXT/PREV buttons are synchronised and
// debounced, and a direct-load strobe is also accepted. The block keeps a
// wrapping game index and holds the CPU in reset for a fixed number of
// cycles after power-up and after every accepted game change.
module game_select_reset_ctrl #(
  parameter int NUM_GAMES       = 16,
  parameter int GAME_W          = 4,
  parameter int RESET_CYCLES    = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_btn,
  input  logic              prev_btn,
  input  logic              load_stb,
  input  logic [GAME_W-1:0] load_idx,
  output logic [GAME_W-1:0] game_idx,
  output logic              cpu_rst_n,
  output logic              game_changed,
  output logic              load_err,
  output logic              busy
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT   = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [GAME_W-1:0] LAST_IDX    = GAME_W'(NUM_GAMES - 1);
  localparam logic [GAME_W:0]   NUM_GAMES_X = (GAME_W + 1)'(NUM_GAMES);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ASSERT = 1'b1;

  // Button bit 0 is NEXT, bit 1 is PREV
  logic [1:0]            raw_btn;
  logic [1:0]            sync1;
  logic [1:0]            sync2;
  logic [1:0]            deb_lvl;
  logic [1:0]            deb_lvl_q;
  logic [1:0][DB_W-1:0]  deb_cnt;

  logic [0:0]            state;
  logic [HOLD_W-1:0]     hold_cnt;

  logic                  req_next;
  logic                  req_prev;
  logic                  load_bad;
  logic                  load_ok;
  logic                  accept;
  logic [GAME_W-1:0]     idx_nxt;

  assign raw_btn = {prev_btn, next_btn};

  // Two-flop synchroniser for the raw asynchronous buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_btn;
      sync2 <= sync1;
    end
  end

  // Debounce: the level flips only after the synced input has disagreed for DEBOUNCE_CYCLES clocks in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_lvl   <= '0;
      deb_lvl_q <= '0;
      deb_cnt   <= '0;
    end else begin
      deb_lvl_q <= deb_lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DB_LAST) begin
          deb_lvl[i] <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // A request is a single-cycle pulse on the debounced rising edge, so a held button asks only once
  assign req_next = deb_lvl[0] & ~deb_lvl_q[0];
  assign req_prev = deb_lvl[1] & ~deb_lvl_q[1];

  // An out-of-range load is flagged in any state and masks button requests that cycle
  assign load_bad = load_stb && ({1'b0, load_idx} >= NUM_GAMES_X);
  assign load_ok  = load_stb && !load_bad;

  // Pick the event accepted this cycle (load, then single button) and the resulting index
  always_comb begin
    accept  = 1'b0;
    idx_nxt = game_idx;
    if (state == ST_IDLE) begin
      if (load_ok) begin
        accept  = 1'b1;
        idx_nxt = load_idx;
      end else if (!load_bad && (req_next != req_prev)) begin
        accept = 1'b1;
        if (req_next) begin
          idx_nxt = (game_idx == LAST_IDX) ? '0 : game_idx + GAME_W'(1);
        end else begin
          idx_nxt = (game_idx == '0) ? LAST_IDX : game_idx - GAME_W'(1);
        end
      end
    end
  end

  // Index, pulses and the reset-hold FSM; every accepted change restarts a full CPU reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_ASSERT;
      hold_cnt     <= HOLD_INIT;
      game_idx     <= '0;
      game_changed <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      game_changed <= accept;
      load_err     <= load_bad;
      if (accept) begin
        state    <= ST_ASSERT;
        hold_cnt <= HOLD_INIT;
        game_idx <= idx_nxt;
      end else if (state == ST_ASSERT) begin
        if (hold_cnt == '0) begin
          state <= ST_IDLE;
        end else begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
        end
      end
    end
  end

  // Reset and busy come straight from the state flop, so no input reaches them combinationally
  assign cpu_rst_n = (state == ST_IDLE);
  assign busy      = (state == ST_ASSERT);

endmodule

// File: tb/tb_game_select_reset_ctrl.sv
// tb_game_select_reset_ctrl
// Drives a 16-game and a 5-game controller from the same inputs and checks
// both against an index model built from modular arithmetic.
module tb_game_select_reset_ctrl;

  localparam int D  = 16;
  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       next_btn;
  logic       prev_btn;
  logic       load_stb;
  logic [3:0] load_idx;

  logic [3:0] game_idx,     game_idx5;
  logic       cpu_rst_n,    cpu_rst_n5;
  logic       game_changed, game_changed5;
  logic       load_err,     load_err5;
  logic       busy,         busy5;

  int n_cmp = 0;
  int n_err = 0;
  int exp16 = 0;
  int exp5  = 0;
  int chg16 = 0;
  int chg5  = 0;
  int err16 = 0;
  int err5c = 0;

  game_select_reset_ctrl #(
    .NUM_GAMES(16), .GAME_W(4), .RESET_CYCLES(RC), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .next_btn(next_btn), .prev_btn(prev_btn),
    .load_stb(load_stb), .load_idx(load_idx), .game_idx(game_idx),
    .cpu_rst_n(cpu_rst_n), .game_changed(game_changed), .load_err(load_err),
    .busy(busy)
  );

  game_select_reset_ctrl #(
    .NUM_GAMES(5), .GAME_W(4), .RESET_CYCLES(RC), .DEBOUNCE_CYCLES(D)
  ) dut5 (
    .clk(clk), .rst(rst), .next_btn(next_btn), .prev_btn(prev_btn),
    .load_stb(load_stb), .load_idx(load_idx), .game_idx(game_idx5),
    .cpu_rst_n(cpu_rst_n5), .game_changed(game_changed5), .load_err(load_err5),
    .busy(busy5)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Count output pulses so tests can check how many changes/errors happened
  always @(negedge clk) begin
    if (game_changed  === 1'b1) chg16++;
    if (game_changed5 === 1'b1) chg5++;
    if (load_err      === 1'b1) err16++;
    if (load_err5     === 1'b1) err5c++;
  end

  // Hard stop in case something hangs
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  // Advance n clocks, leaving time 1 ns after the last rising edge
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    next_btn = 1'b0;
    prev_btn = 1'b0;
    load_stb = 1'b0;
    load_idx = 4'd0;
  endtask

  // Wait until both controllers have released the CPU, bounded
  task automatic wait_idle();
    int k;
    k = 0;
    while (!(cpu_rst_n === 1'b1 && cpu_rst_n5 === 1'b1) && k < 40) begin
      cycles(1);
      k++;
    end
    if (k >= 40) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL wait_idle: cpu_rst_n=%b/%b required 1/1 within 40 clocks", cpu_rst_n, cpu_rst_n5);
    end
  endtask

  // One-cycle load strobe; returns just after the accepting edge
  task automatic do_load(input logic [3:0] v);
    load_stb = 1'b1;
    load_idx = v;
    cycles(1);
    load_stb = 1'b0;
  endtask

  // Bounce, hold, release and let everything settle
  task automatic press(input bit nx, input bit pv, input int bounce, input int hold);
    for (int b = 0; b < bounce; b++) begin
      next_btn = nx & 1'($urandom);
      prev_btn = pv & 1'($urandom);
      cycles(1);
    end
    next_btn = nx;
    prev_btn = pv;
    cycles(hold);
    next_btn = 1'b0;
    prev_btn = 1'b0;
    cycles(D + 6);
    wait_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    cycles(3);
    n_cmp++;
    if ({game_idx, cpu_rst_n, busy, game_changed, load_err} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL reset_state: idx=%0d rst_n=%b busy=%b chg=%b err=%b required 0 0 1 0 0",
               game_idx, cpu_rst_n, busy, game_changed, load_err);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cycles(1);
      n_cmp++;
      if (cpu_rst_n !== (k >= RC) || busy !== (k < RC) || cpu_rst_n5 !== (k >= RC) || game_idx !== 4'd0) begin
        n_err++;
        $display("[TB] FAIL reset_release clk%0d: rst_n=%b busy=%b rst_n5=%b idx=%0d required rst_n=%0d idx=0",
                 k, cpu_rst_n, busy, cpu_rst_n5, game_idx, (k >= RC));
      end
    end
    exp16 = 0;
    exp5  = 0;
  endtask

  task automatic test_next_latency();
    bit early_ok;
    int lows;
    int c16;
    early_ok = 1'b1;
    lows = 0;
    c16 = chg16;
    next_btn = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      cycles(1);
      if (game_idx !== 4'd0 || game_changed !== 1'b0 || cpu_rst_n !== 1'b1) early_ok = 1'b0;
    end
    n_cmp++;
    if (!early_ok) begin
      n_err++;
      $display("[TB] FAIL next_early: index changed before clock 19, now idx=%0d required 0 until clock 19", game_idx);
    end
    cycles(1);
    n_cmp++;
    if (game_idx !== 4'd1 || game_changed !== 1'b1 || cpu_rst_n !== 1'b0 || game_idx5 !== 4'd1) begin
      n_err++;
      $display("[TB] FAIL next_clock19: idx=%0d chg=%b rst_n=%b idx5=%0d required 1 1 0 1",
               game_idx, game_changed, cpu_rst_n, game_idx5);
    end
    if (cpu_rst_n === 1'b0) lows++;
    for (int k = 20; k <= 30; k++) begin
      cycles(1);
      if (cpu_rst_n === 1'b0) lows++;
    end
    n_cmp++;
    if (lows != RC) begin
      n_err++;
      $display("[TB] FAIL next_reset_len: cpu_rst_n low %0d clocks, required %0d", lows, RC);
    end
    cycles(500);
    n_cmp++;
    if (game_idx !== 4'd1 || chg16 - c16 != 1) begin
      n_err++;
      $display("[TB] FAIL next_hold: idx=%0d changes=%0d required idx=1 changes=1", game_idx, chg16 - c16);
    end
    next_btn = 1'b0;
    cycles(D + 6);
    n_cmp++;
    if (game_idx !== 4'd1 || game_idx5 !== 4'd1 || chg16 - c16 != 1) begin
      n_err++;
      $display("[TB] FAIL next_release: idx=%0d idx5=%0d changes=%0d required 1 1 1", game_idx, game_idx5, chg16 - c16);
    end
    exp16 = 1;
    exp5  = 1;
  endtask

  task automatic test_bounce();
    bit low_seen;
    int c16;
    low_seen = 1'b0;
    c16 = chg16;
    for (int c = 0; c < 200; c++) begin
      if (c % 5 == 0) next_btn = ~next_btn;
      cycles(1);
      if (cpu_rst_n !== 1'b1) low_seen = 1'b1;
    end
    next_btn = 1'b0;
    cycles(D + 6);
    n_cmp++;
    if (low_seen || game_idx !== 4'(exp16) || chg16 - c16 != 0) begin
      n_err++;
      $display("[TB] FAIL bounce: rst_low_seen=%b idx=%0d changes=%0d required 0 %0d 0",
               low_seen, game_idx, chg16 - c16, exp16);
    end
  endtask

  task automatic test_wrap();
    wait_idle();
    do_load(4'd4);
    n_cmp++;
    if (game_idx !== 4'd4 || game_idx5 !== 4'd4 || game_changed !== 1'b1 || game_changed5 !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL wrap_load4: idx=%0d idx5=%0d chg=%b/%b required 4 4 1/1",
               game_idx, game_idx5, game_changed, game_changed5);
    end
    wait_idle();
    press(1'b1, 1'b0, 0, 30);
    n_cmp++;
    if (game_idx !== 4'd5 || game_idx5 !== 4'd0) begin
      n_err++;
      $display("[TB] FAIL wrap_next5: idx=%0d idx5=%0d required 5 0", game_idx, game_idx5);
    end
    do_load(4'd15);
    n_cmp++;
    if (game_idx !== 4'd15 || game_idx5 !== 4'd0 || load_err5 !== 1'b1 || game_changed5 !== 1'b0 || cpu_rst_n5 !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL wrap_load15: idx=%0d idx5=%0d err5=%b chg5=%b rst_n5=%b required 15 0 1 0 1",
               game_idx, game_idx5, load_err5, game_changed5, cpu_rst_n5);
    end
    wait_idle();
    press(1'b1, 1'b0, 0, 30);
    n_cmp++;
    if (game_idx !== 4'd0 || game_idx5 !== 4'd1) begin
      n_err++;
      $display("[TB] FAIL wrap_next15: idx=%0d idx5=%0d required 0 1", game_idx, game_idx5);
    end
    press(1'b0, 1'b1, 0, 30);
    n_cmp++;
    if (game_idx !== 4'd15 || game_idx5 !== 4'd0) begin
      n_err++;
      $display("[TB] FAIL wrap_prev0: idx=%0d idx5=%0d required 15 0", game_idx, game_idx5);
    end
    press(1'b0, 1'b1, 0, 30);
    n_cmp++;
    if (game_idx !== 4'd14 || game_idx5 !== 4'd4) begin
      n_err++;
      $display("[TB] FAIL wrap_prev5: idx=%0d idx5=%0d required 14 4", game_idx, game_idx5);
    end
    exp16 = 14;
    exp5  = 4;
  endtask

  task automatic test_load();
    wait_idle();
    load_stb = 1'b1;
    load_idx = 4'd9;
    cycles(1);
    n_cmp++;
    if (game_idx !== 4'd9 || game_changed !== 1'b1 || cpu_rst_n !== 1'b0 || busy !== 1'b1 || load_err !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL load9: idx=%0d chg=%b rst_n=%b busy=%b err=%b required 9 1 0 1 0",
               game_idx, game_changed, cpu_rst_n, busy, load_err);
    end
    n_cmp++;
    if (game_idx5 !== 4'd4 || load_err5 !== 1'b1 || game_changed5 !== 1'b0 || cpu_rst_n5 !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL load9_bad5: idx5=%0d err5=%b chg5=%b rst_n5=%b required 4 1 0 1",
               game_idx5, load_err5, game_changed5, cpu_rst_n5);
    end
    load_idx = 4'd3;
    cycles(1);
    n_cmp++;
    if (game_idx !== 4'd9 || game_changed !== 1'b0 || game_idx5 !== 4'd3 || game_changed5 !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL load_in_assert: idx=%0d chg=%b idx5=%0d chg5=%b required 9 0 3 1",
               game_idx, game_changed, game_idx5, game_changed5);
    end
    load_idx = 4'd7;
    cycles(1);
    load_stb = 1'b0;
    n_cmp++;
    if (game_idx !== 4'd9 || load_err !== 1'b0 || game_idx5 !== 4'd3 || load_err5 !== 1'b1 || game_changed5 !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL load_err_in_assert: idx=%0d err=%b idx5=%0d err5=%b chg5=%b required 9 0 3 1 0",
               game_idx, load_err, game_idx5, load_err5, game_changed5);
    end
    wait_idle();
    do_load(4'd9);
    n_cmp++;
    if (game_idx !== 4'd9 || game_changed !== 1'b1 || cpu_rst_n !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL load_same: idx=%0d chg=%b rst_n=%b required 9 1 0", game_idx, game_changed, cpu_rst_n);
    end
    wait_idle();
    exp16 = 9;
    exp5  = 3;
  endtask

  task automatic test_priority();
    int c16;
    int c5;
    c16 = chg16;
    c5  = chg5;
    next_btn = 1'b1;
    cycles(18);
    load_stb = 1'b1;
    load_idx = 4'd2;
    cycles(1);
    load_stb = 1'b0;
    n_cmp++;
    if (game_idx !== 4'd2 || game_idx5 !== 4'd2 || game_changed !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL load_beats_next: idx=%0d idx5=%0d chg=%b required 2 2 1", game_idx, game_idx5, game_changed);
    end
    cycles(10);
    next_btn = 1'b0;
    cycles(D + 6);
    wait_idle();
    n_cmp++;
    if (game_idx !== 4'd2 || chg16 - c16 != 1 || chg5 - c5 != 1) begin
      n_err++;
      $display("[TB] FAIL load_beats_next_after: idx=%0d changes=%0d/%0d required 2 1/1", game_idx, chg16 - c16, chg5 - c5);
    end
    c16 = chg16;
    c5  = chg5;
    next_btn = 1'b1;
    cycles(18);
    load_stb = 1'b1;
    load_idx = 4'd12;
    cycles(1);
    load_stb = 1'b0;
    cycles(10);
    next_btn = 1'b0;
    cycles(D + 6);
    wait_idle();
    n_cmp++;
    if (game_idx !== 4'd12 || game_idx5 !== 4'd2 || chg16 - c16 != 1 || chg5 - c5 != 0) begin
      n_err++;
      $display("[TB] FAIL bad_load_drops_next: idx=%0d idx5=%0d changes=%0d/%0d required 12 2 1/0",
               game_idx, game_idx5, chg16 - c16, chg5 - c5);
    end
    c16 = chg16;
    c5  = chg5;
    press(1'b1, 1'b1, 0, 30);
    n_cmp++;
    if (game_idx !== 4'd12 || game_idx5 !== 4'd2 || chg16 - c16 != 0 || chg5 - c5 != 0) begin
      n_err++;
      $display("[TB] FAIL next_and_prev: idx=%0d idx5=%0d changes=%0d/%0d required 12 2 0/0",
               game_idx, game_idx5, chg16 - c16, chg5 - c5);
    end
    exp16 = 12;
    exp5  = 2;
  endtask

  task automatic test_reset_mid();
    int c16;
    do_load(4'd7);
    n_cmp++;
    if (game_idx !== 4'd7 || cpu_rst_n !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mid_load7: idx=%0d rst_n=%b required 7 0", game_idx, cpu_rst_n);
    end
    rst = 1'b1;
    cycles(1);
    n_cmp++;
    if (game_idx !== 4'd0 || game_idx5 !== 4'd0 || cpu_rst_n !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL mid_reset_state: idx=%0d idx5=%0d rst_n=%b busy=%b required 0 0 0 1",
               game_idx, game_idx5, cpu_rst_n, busy);
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cycles(1);
      n_cmp++;
      if (cpu_rst_n !== (k >= RC) || game_idx !== 4'd0) begin
        n_err++;
        $display("[TB] FAIL mid_reset_release clk%0d: rst_n=%b idx=%0d required rst_n=%0d idx=0",
                 k, cpu_rst_n, game_idx, (k >= RC));
      end
    end
    c16 = chg16;
    next_btn = 1'b1;
    cycles(12);
    rst = 1'b1;
    next_btn = 1'b0;
    cycles(1);
    rst = 1'b0;
    cycles(D + 10);
    n_cmp++;
    if (game_idx !== 4'd0 || chg16 - c16 != 0 || cpu_rst_n !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_mid_debounce: idx=%0d changes=%0d rst_n=%b required 0 0 1",
               game_idx, chg16 - c16, cpu_rst_n);
    end
    exp16 = 0;
    exp5  = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int op;
      int v;
      int c16;
      int c5;
      int e16;
      int e5;
      int x16;
      int x5;
      int xe5;
      op  = int'($urandom_range(0, 4));
      c16 = chg16;
      c5  = chg5;
      e16 = err16;
      e5  = err5c;
      x16 = 0;
      x5  = 0;
      xe5 = 0;
      case (op)
        0: begin
          press(1'b1, 1'b0, int'($urandom_range(0, 10)), int'($urandom_range(22, 40)));
          exp16 = (exp16 + 1) % 16;
          exp5  = (exp5 + 1) % 5;
          x16 = 1;
          x5  = 1;
        end
        1: begin
          press(1'b0, 1'b1, int'($urandom_range(0, 10)), int'($urandom_range(22, 40)));
          exp16 = (exp16 + 15) % 16;
          exp5  = (exp5 + 4) % 5;
          x16 = 1;
          x5  = 1;
        end
        2: begin
          press(1'b1, 1'b1, 0, int'($urandom_range(22, 40)));
        end
        default: begin
          v = int'($urandom_range(0, 15));
          do_load(4'(v));
          wait_idle();
          exp16 = v;
          x16 = 1;
          if (v < 5) begin
            exp5 = v;
            x5 = 1;
          end else begin
            xe5 = 1;
          end
        end
      endcase
      n_cmp++;
      if (game_idx !== 4'(exp16) || game_idx5 !== 4'(exp5) || chg16 - c16 != x16 || chg5 - c5 != x5 ||
          err16 - e16 != 0 || err5c - e5 != xe5) begin
        n_err++;
        $display("[TB] FAIL random op%0d kind%0d: idx=%0d/%0d chg=%0d/%0d err=%0d/%0d required %0d/%0d chg=%0d/%0d err=0/%0d",
                 i, op, game_idx, game_idx5, chg16 - c16, chg5 - c5, err16 - e16, err5c - e5,
                 exp16, exp5, x16, x5, xe5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_next_latency();
    test_bounce();
    test_wrap();
    test_load();
    test_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
